// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin front end that lets two requesters share one
//               iterative divider. One transaction is in flight at a time:
//               IDLE grants a requester, ISSUE pulses the divider, WAIT
//               collects the quotient (or times out), RESP holds the result
//               until the owning requester consumes it. Divide-by-zero
//               requests are answered directly without touching the divider.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               reqN_valid/ready      - request handshake (N = 0,1)
//               reqN_dividend/divisor - operands, stable while reqN_valid
//               rspN_valid/ready      - response handshake
//               rspN_data/err         - quotient / error flag
//               div_in_*              - start pulse and operands to divider
//               div_out_valid/data    - divider result strobe and quotient
//               busy                  - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [9:0]  req0_dividend,
    input  logic [2:0]  req0_divisor,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [19:0] rsp0_data,
    output logic        rsp0_err,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    input  logic [9:0]  req1_dividend,
    input  logic [2:0]  req1_divisor,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [19:0] rsp1_data,
    output logic        rsp1_err,
    input  logic        rsp1_ready,
    output logic        div_in_valid,
    output logic [9:0]  div_in_data_1,
    output logic [2:0]  div_in_data_2,
    input  logic        div_out_valid,
    input  logic [19:0] div_out_data,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The count starts at 0 in the first WAIT cycle, so the abort happens on
    // the WAIT cycle whose count is TIMEOUT-1, i.e. after TIMEOUT WAIT cycles.
    localparam logic [7:0]  CNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [19:0] DIV0_DATA = 20'hFFFFF;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        prio;
    logic        owner;
    logic [9:0]  dividend;
    logic [2:0]  divisor;
    logic [7:0]  wait_cnt;
    logic [19:0] rsp_data;
    logic        rsp_err;

    logic        grant_id;
    logic        handshake;
    logic [9:0]  grant_dividend;
    logic [2:0]  grant_divisor;
    logic        timeout_hit;
    logic        rsp_take;

    // Grant selection: a lone requester always wins, a tie goes to prio.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end else begin
            grant_id = req1_valid;
        end
        grant_dividend = grant_id ? req1_dividend : req0_dividend;
        grant_divisor  = grant_id ? req1_divisor  : req0_divisor;
        handshake      = rst_n && (state == S_IDLE) && (req0_valid || req1_valid);
        timeout_hit    = (wait_cnt == CNT_LAST);
        rsp_take       = owner ? rsp1_ready : rsp0_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_nxt = (grant_divisor == 3'd0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (div_out_valid || timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_take) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            owner    <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        owner    <= grant_id;
                        dividend <= grant_dividend;
                        divisor  <= grant_divisor;
                        wait_cnt <= '0;
                        if (grant_divisor == 3'd0) begin
                            rsp_data <= DIV0_DATA;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (div_out_valid) begin
                        rsp_data <= div_out_data;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_take) begin
                        prio     <= ~owner;
                        dividend <= '0;
                        divisor  <= '0;
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req0_ready    = handshake && (grant_id == 1'b0);
        req1_ready    = handshake && (grant_id == 1'b1);
        div_in_valid  = (state == S_ISSUE);
        div_in_data_1 = '0;
        div_in_data_2 = '0;
        if ((state == S_ISSUE) || (state == S_WAIT)) begin
            div_in_data_1 = dividend;
            div_in_data_2 = divisor;
        end
        rsp0_valid = (state == S_RESP) && (owner == 1'b0);
        rsp1_valid = (state == S_RESP) && (owner == 1'b1);
        rsp0_data  = rsp0_valid ? rsp_data : '0;
        rsp0_err   = rsp0_valid ? rsp_err  : 1'b0;
        rsp1_data  = rsp1_valid ? rsp_data : '0;
        rsp1_err   = rsp1_valid ? rsp_err  : 1'b0;
        busy       = (state != S_IDLE);
    end

endmodule
`default_nettype wire
